// File: rtl/ipsmacge_txtoscan.sv
// ============================================================================
//  Module      : ipsmacge_txtoscan
//  Description : Multi-channel transmit-timeout scanner for the GE MAC TX
//                path. A round-robin pointer walks NCH channels, skipping
//                idle ones in a single cycle. For a channel whose request is
//                waiting it times how long the channel stays blocked and
//                raises a held valid/ack event once the wait reaches the
//                programmed threshold. Reported events are counted in a
//                saturating counter.
//  Ports       : clk      - clock
//                rst_     - asynchronous active-low reset
//                upact    - scan enable (low: pointer frozen, wait cleared)
//                paudis   - pause active (clears wait, suppresses timeout)
//                cfgthr   - timeout threshold, 0 disables detection
//                reqwait  - per-channel "request waiting" flags
//                toval    - timeout event valid (held until toack)
//                toid     - channel id of the pending event
//                toack    - event acknowledge
//                curid    - current scan pointer
//                tocnt    - saturating count of reported timeouts
//                stkclr   - (optional) per-channel sticky clear, write-1
//                tostk    - (optional) per-channel sticky timeout status
//  Options     : IPSMACGE_TXTO_STICKY_EN adds the stkclr/tostk sticky status.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ipsmacge_txtoscan #(
    parameter int NCH    = 256,
    parameter int IDBIT  = 8,
    parameter int CNTBIT = 8,
    parameter int EVBIT  = 16
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              upact,
    input  logic              paudis,
    input  logic [CNTBIT-1:0] cfgthr,
    input  logic [NCH-1:0]    reqwait,
    output logic              toval,
    output logic [IDBIT-1:0]  toid,
    input  logic              toack,
    output logic [IDBIT-1:0]  curid,
    output logic [EVBIT-1:0]  tocnt
`ifdef IPSMACGE_TXTO_STICKY_EN
    ,
    input  logic [NCH-1:0]    stkclr,
    output logic [NCH-1:0]    tostk
`endif
);

    typedef enum logic [1:0] {
        ST_SCAN   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    localparam logic [IDBIT-1:0] c_last_id = IDBIT'(NCH - 1);
    localparam logic [EVBIT-1:0] c_ev_max  = '1;

    state_t            r_state;
    logic [CNTBIT-1:0] r_cnt;
    logic [IDBIT-1:0]  r_curid;
    logic [IDBIT-1:0]  r_toid;
    logic              r_toval;
    logic [EVBIT-1:0]  r_tocnt;

    logic              w_req;
    logic [IDBIT-1:0]  w_next_id;
    logic              w_rep_entry;

    // Request flag of the channel under the pointer; ids beyond NCH read 0.
    always_comb begin
        w_req = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (r_curid == IDBIT'(i)) begin
                w_req = reqwait[i];
            end
        end
    end

    assign w_next_id = (r_curid == c_last_id) ? '0 : r_curid + IDBIT'(1);

    // Same priority chain as the WAIT branch below, collapsed to one term so
    // the event counter and the sticky bits share the exact entry condition.
    assign w_rep_entry = (r_state == ST_WAIT) && upact && w_req && !paudis &&
                         (r_cnt == cfgthr);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= ST_SCAN;
            r_cnt   <= '0;
            r_curid <= '0;
            r_toid  <= '0;
            r_toval <= 1'b0;
            r_tocnt <= '0;
        end else begin
            case (r_state)
                ST_SCAN: begin
                    if (!upact) begin
                        r_cnt <= '0;
                    end else if (w_req && (cfgthr != '0)) begin
                        r_state <= ST_WAIT;
                        r_cnt   <= '0;
                    end else begin
                        r_curid <= w_next_id;
                    end
                end
                ST_WAIT: begin
                    if (!upact) begin
                        r_state <= ST_SCAN;
                        r_cnt   <= '0;
                    end else if (!w_req) begin
                        r_state <= ST_SCAN;
                        r_curid <= w_next_id;
                    end else if (paudis) begin
                        r_cnt <= '0;
                    end else if (r_cnt == cfgthr) begin
                        r_state <= ST_REPORT;
                        r_toval <= 1'b1;
                        r_toid  <= r_curid;
                    end else begin
                        // Free-running wrap: a threshold lowered below the
                        // current count is met only after the count wraps.
                        r_cnt <= r_cnt + CNTBIT'(1);
                    end
                end
                ST_REPORT: begin
                    // All scan inputs are ignored here so the event survives
                    // until it is acknowledged.
                    if (toack) begin
                        r_state <= ST_SCAN;
                        r_toval <= 1'b0;
                        r_curid <= w_next_id;
                    end
                end
                default: begin
                    r_state <= ST_SCAN;
                    r_toval <= 1'b0;
                end
            endcase

            if (w_rep_entry && (r_tocnt != c_ev_max)) begin
                r_tocnt <= r_tocnt + EVBIT'(1);
            end
        end
    end

    assign toval = r_toval;
    assign toid  = r_toid;
    assign curid = r_curid;
    assign tocnt = r_tocnt;

`ifdef IPSMACGE_TXTO_STICKY_EN
    logic [NCH-1:0] r_stk;
    logic [NCH-1:0] w_stk_set;

    assign w_stk_set = w_rep_entry ? (NCH'(1) << r_curid) : '0;

    // Set is OR-ed after the clear so a same-cycle set wins.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_stk <= '0;
        end else begin
            r_stk <= (r_stk & ~stkclr) | w_stk_set;
        end
    end

    assign tostk = r_stk;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ipsmacge_txtoscan.sv
// ============================================================================
//  Module      : tb_ipsmacge_txtoscan
//  Description : Self-checking bench for ipsmacge_txtoscan. Directed scenarios
//                plus a randomized phase, all compared every cycle against a
//                behavioural model of the scanner rules.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ipsmacge_txtoscan;

    localparam int NCH    = 8;
    localparam int IDBIT  = 4;
    localparam int CNTBIT = 4;
    localparam int EVBIT  = 4;
    localparam int C_CNT_MOD = 1 << CNTBIT;
    localparam int C_EV_MAX  = (1 << EVBIT) - 1;

    logic              clk;
    logic              rst_;
    logic              upact;
    logic              paudis;
    logic [CNTBIT-1:0] cfgthr;
    logic [NCH-1:0]    reqwait;
    logic              toval;
    logic [IDBIT-1:0]  toid;
    logic              toack;
    logic [IDBIT-1:0]  curid;
    logic [EVBIT-1:0]  tocnt;
`ifdef IPSMACGE_TXTO_STICKY_EN
    logic [NCH-1:0]    stkclr;
    logic [NCH-1:0]    tostk;
`endif

    ipsmacge_txtoscan #(
        .NCH    (NCH),
        .IDBIT  (IDBIT),
        .CNTBIT (CNTBIT),
        .EVBIT  (EVBIT)
    ) u_dut (
        .clk     (clk),
        .rst_    (rst_),
        .upact   (upact),
        .paudis  (paudis),
        .cfgthr  (cfgthr),
        .reqwait (reqwait),
        .toval   (toval),
        .toid    (toid),
        .toack   (toack),
        .curid   (curid),
        .tocnt   (tocnt)
`ifdef IPSMACGE_TXTO_STICKY_EN
        ,
        .stkclr  (stkclr),
        .tostk   (tostk)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: a channel "waiting" flag, a "pending event" flag,
    // the blocked-time count and the observable outputs.
    int       m_cur, m_cnt, m_toid, m_tocnt;
    bit       m_waiting, m_pending;
    logic [NCH-1:0] m_stk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cur = 0; m_cnt = 0; m_toid = 0; m_tocnt = 0;
        m_waiting = 0; m_pending = 0; m_stk = '0;
    endtask

    // One clock edge of the scanner rules, using the inputs present now.
    task automatic model_step();
        bit req;
        req = reqwait[m_cur];
`ifdef IPSMACGE_TXTO_STICKY_EN
        m_stk = m_stk & ~stkclr;
`endif
        if (m_pending) begin
            if (toack) begin
                m_pending = 0;
                m_cur = (m_cur + 1) % NCH;
            end
        end else if (!m_waiting) begin
            if (!upact) m_cnt = 0;
            else if (cfgthr == 0 || !req) m_cur = (m_cur + 1) % NCH;
            else begin m_waiting = 1; m_cnt = 0; end
        end else begin
            if (!upact) begin m_waiting = 0; m_cnt = 0; end
            else if (!req) begin m_waiting = 0; m_cur = (m_cur + 1) % NCH; end
            else if (paudis) m_cnt = 0;
            else if (m_cnt == int'(cfgthr)) begin
                m_waiting = 0;
                m_pending = 1;
                m_toid = m_cur;
                if (m_tocnt < C_EV_MAX) m_tocnt++;
                m_stk[m_cur] = 1'b1;
            end else m_cnt = (m_cnt + 1) % C_CNT_MOD;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("toval", toval, m_pending);
        chk("toid",  toid,  m_toid);
        chk("curid", curid, m_cur);
        chk("tocnt", tocnt, m_tocnt);
`ifdef IPSMACGE_TXTO_STICKY_EN
        chk("tostk", tostk, m_stk);
`endif
    endtask

    task automatic do_reset();
        rst_ = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_toval", toval, 0);
        chk("rst_toid",  toid,  0);
        chk("rst_curid", curid, 0);
        chk("rst_tocnt", tocnt, 0);
        @(negedge clk);
        rst_ = 1'b1;
    endtask

    task automatic wait_cur(input int id);
        for (int i = 0; i < 40; i++) begin
            if (curid == IDBIT'(id)) break;
            cyc();
        end
        chk("wait_cur", curid, id);
    endtask

    task automatic count_toval(output int n);
        n = 0;
        while (!toval && n < 60) begin
            cyc();
            n++;
        end
    endtask

    task automatic ack_event();
        toack = 1'b1;
        cyc();
        toack = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        upact = 0; paudis = 0; cfgthr = '0; reqwait = '0; toack = 0;
`ifdef IPSMACGE_TXTO_STICKY_EN
        stkclr = '0;
`endif
        do_reset();

        // Idle sweep
        upact = 1; cfgthr = 4;
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk("sweep_cur", curid, (i + 1) % NCH);
            chk("sweep_val", toval, 0);
        end

        // Timeout on channel 3 with a long-held event
        reqwait = 8'b0000_1000;
        wait_cur(3);
        count_toval(n);
        chk("to_lat", n, 6);
        chk("to_id", toid, 3);
        chk("to_cnt", tocnt, 1);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("hold_val", toval, 1);
            chk("hold_id", toid, 3);
        end
        ack_event();
        chk("ack_val", toval, 0);
        chk("ack_cur", curid, 4);

        // Pause at wait count 3 delays the event by 4 cycles
        reqwait = 8'b0000_0100; cfgthr = 5;
        wait_cur(2);
        repeat (4) cyc();
        paudis = 1;
        cyc();
        paudis = 0;
        count_toval(n);
        chk("pause_lat", 5 + n, 11);
        ack_event();

        // Release at wait count 2: no event, pointer moves on
        wait_cur(2);
        repeat (3) cyc();
        reqwait = '0;
        cyc();
        chk("rel_cur", curid, 3);
        chk("rel_val", toval, 0);

        // upact drop in WAIT, then in REPORT
        reqwait = 8'b0100_0000; cfgthr = 4;
        wait_cur(6);
        repeat (3) cyc();
        upact = 0;
        repeat (2) cyc();
        chk("updrop_cur", curid, 6);
        upact = 1;
        count_toval(n);
        chk("updrop_lat", n, 6);
        upact = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("rep_hold", toval, 1);
        end
        ack_event();
        chk("rep_ack_cur", curid, 7);
        upact = 1; reqwait = '0;

        // Threshold 0: free-running sweep even with all channels waiting
        reqwait = '1; cfgthr = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("thr0_val", toval, 0);
        end

        // Threshold lowered below the running count: wrap before firing
        reqwait = 8'b0000_0010; cfgthr = 10;
        wait_cur(1);
        repeat (9) cyc();
        cfgthr = 3;
        count_toval(n);
        chk("wrap_lat", 9 + n, 21);
        ack_event();
        reqwait = '0;

        // Randomized phase
        for (int i = 0; i < 500; i++) begin
            if (i % 8 == 0) reqwait = NCH'($urandom & $urandom);
            if (i % 37 == 0) cfgthr = CNTBIT'($urandom_range(1, 6));
            upact  = ($urandom_range(0, 9) != 0);
            paudis = ($urandom_range(0, 9) == 0);
            toack  = ($urandom_range(0, 2) == 0);
`ifdef IPSMACGE_TXTO_STICKY_EN
            stkclr = NCH'($urandom & $urandom & $urandom);
`endif
            cyc();
        end
        upact = 1; paudis = 0; toack = 0; reqwait = '0;
`ifdef IPSMACGE_TXTO_STICKY_EN
        stkclr = '0;
`endif

        // Event counter saturation
        do_reset();
        upact = 1; cfgthr = 1; reqwait = '1; toack = 1;
        repeat (150) cyc();
        chk("sat_cnt", tocnt, C_EV_MAX);

        // Asynchronous reset while an event is pending
        toack = 0;
        count_toval(n);
        chk("pre_rst_val", toval, 1);
        #2;
        rst_ = 1'b0;
        #1;
        chk("arst_val", toval, 0);
        chk("arst_id", toid, 0);
        chk("arst_cur", curid, 0);
        chk("arst_cnt", tocnt, 0);
        model_reset();
        reqwait = '0;
        @(negedge clk);
        rst_ = 1'b1;
        cyc();

`ifdef IPSMACGE_TXTO_STICKY_EN
        // Sticky status: set, set-wins-over-clear, then clear
        cfgthr = 2; reqwait = 8'b0010_0000;
        count_toval(n);
        chk("stk_set", tostk[5], 1);
        ack_event();
        wait_cur(5);
        repeat (3) cyc();
        stkclr = 8'b0010_0000;
        cyc();
        stkclr = '0;
        chk("stk_rep", toval, 1);
        chk("stk_win", tostk[5], 1);
        ack_event();
        reqwait = '0;
        cyc();
        stkclr = 8'b0010_0000;
        cyc();
        stkclr = '0;
        chk("stk_clr", tostk[5], 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
